weight_pingpong_buffer: RTL and testbench
=========================================

WEIGHT_PINGPONG_BUFFER -- requirements
Module: weight_pingpong_buffer

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 64, AXI-Stream beat width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 8, input channels per kernel set.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, bits per weight.
REQ-004 SHALL have parameter FILTER_SIZE, default 3, kernel edge length.
REQ-005 SHALL have parameter KERNELS_PER_LINE, default 2, kernel sets per bank line.
REQ-006 SHALL have parameter BANK_DEPTH, default 256, lines per bank.
REQ-007 SHALL derive KSET_W=NUM_CHANNELS*FILTER_SIZE^2*DATA_WIDTH, LINE_W=KERNELS_PER_LINE*KSET_W, BEATS=LINE_W/AXIS_DATA_WIDTH; LINE_W not divisible by AXIS_DATA_WIDTH is an elaboration error.
REQ-008 SHALL have clk input 1, sole clock, all logic on rising edge.
REQ-009 SHALL have rst input 1, asynchronous, active-high reset.
REQ-010 SHALL have s_axis_tvalid input 1, s_axis_tready output 1, s_axis_tdata input AXIS_DATA_WIDTH, s_axis_tlast input 1: weight stream.
REQ-011 SHALL have i_load_start input 1, pulse starting a load into the write bank.
REQ-012 SHALL have i_load_lines input $clog2(BANK_DEPTH+1), lines to load, sampled with i_load_start.
REQ-013 SHALL have i_swap input 1, exchange write and read banks.
REQ-014 SHALL have i_read_en input 1 and i_read_addr input $clog2(BANK_DEPTH): read port on read bank.
REQ-015 SHALL have o_kernels_packed output LINE_W, o_rd_valid output 1: read data and its qualifier.
REQ-016 SHALL have o_load_done output 1, o_wr_bank output 1, o_err_tlast output 1 (sticky framing error).

Function
REQ-017 SHALL implement two banks of BANK_DEPTH x LINE_W; write bank = o_wr_bank, read bank = ~o_wr_bank.
REQ-018 SHALL implement FSM IDLE, LOAD, DONE; s_axis_tready=1 only in LOAD.
REQ-019 IDLE: i_load_start -> LOAD, wr_addr=0, beat=0, target=min(i_load_lines,BANK_DEPTH); target 0 -> DONE directly.
REQ-020 LOAD: each handshake places tdata at line bits [beat*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] (first beat lowest), beat++.
REQ-021 LOAD: handshake with beat==BEATS-1 writes assembled line to write bank at wr_addr, wr_addr++, beat=0; when wr_addr reaches target, FSM -> DONE next cycle, tready low that cycle.
REQ-022 tlast SHALL be expected exactly on beat BEATS-1; tlast missing there sets o_err_tlast, line still written.
REQ-023 tlast on beat<BEATS-1 SHALL set o_err_tlast, discard partial line, beat=0, wr_addr unchanged.
REQ-024 DONE: o_load_done=1 (level); i_swap toggles o_wr_bank, -> IDLE, o_load_done=0.
REQ-025 i_swap outside DONE and i_load_start outside IDLE SHALL be ignored.
REQ-026 Read: i_read_en=1 in cycle N -> o_kernels_packed = read bank[i_read_addr] and o_rd_valid=1 in cycle N+1; i_read_en=0 -> o_kernels_packed holds, o_rd_valid=0.
REQ-027 Kernel set k SHALL occupy o_kernels_packed[k*KSET_W +: KSET_W].
REQ-028 Read and swap in same cycle SHALL read the pre-swap read bank.
REQ-029 Reads SHALL proceed concurrently with LOAD without stalling either side.
REQ-030 o_err_tlast SHALL clear only on rst or i_load_start accepted in IDLE.

Reset
REQ-031 rst SHALL force FSM IDLE, s_axis_tready=0, o_wr_bank=0, o_load_done=0, o_err_tlast=0, o_rd_valid=0, o_kernels_packed=0, wr_addr=0, beat=0.
REQ-032 rst mid-LOAD SHALL abort the load, partial line discarded; bank contents SHALL NOT be cleared.

Verification
REQ-033 Defaults, load 2 lines, beats 1..18 then 0xA0..0xB1, tlast on each 18th beat, swap; read addr 0,1 -> lines match low-beat-first packing, o_rd_valid one cycle after i_read_en, o_err_tlast=0.
REQ-034 After REQ-033 swap, load 1 line of 0x55 into bank 1 while reading bank 0 addr 1 every cycle -> reads stay line 0xA0..0xB1 throughout; swap then read addr 0 -> all beats 0x55.
REQ-035 tlast on beat 5 of line 0, then 18 clean beats -> o_err_tlast=1, addr 0 holds clean beats, load completes after 1 good line of target 1.
REQ-036 i_load_lines=0 -> DONE next cycle, no tready; i_load_lines=BANK_DEPTH+1 clamps -> exactly 256 lines accepted, tready low after 4608th beat.
REQ-037 rst asserted after beat 10 of line 3 -> all outputs at reset values asynchronously; lines 0-2 readable after new load/swap sequence unaffected by garbage.
REQ-038 i_swap pulsed in LOAD and i_load_start pulsed in DONE -> no effect on o_wr_bank or FSM.

Source files
------------

// File: rtl/weight_pingpong_buffer.sv
// rtl/weight_pingpong_buffer.sv - ping-pong weight line store filled from an AXI-Stream beat stream
//
// Ports:
//   clk, rst          : sole clock (rising edge), asynchronous active-high reset
//   s_axis_tdata      : weight beat, first beat of a line lands in the lowest bits
//   s_axis_tvalid     : beat valid
//   s_axis_tready     : high only while a load is in progress
//   s_axis_tlast      : marks the final beat of each line
//   i_load_start      : pulse, starts a load into the write bank (accepted in IDLE only)
//   i_load_lines      : number of lines to load, sampled with i_load_start, clamped to BANK_DEPTH
//   i_swap            : exchange write/read banks (accepted in DONE only)
//   i_read_en         : read request on the read bank
//   i_read_addr       : line address for the read request
//   o_kernels_packed  : read line, kernel set k at [k*KSET_W +: KSET_W], one cycle after i_read_en
//   o_rd_valid        : qualifies o_kernels_packed for the cycle after i_read_en
//   o_load_done       : level, load finished and waiting for i_swap
//   o_wr_bank         : bank currently written; the other bank is read
//   o_err_tlast       : sticky tlast framing error, cleared by rst or an accepted load start
module weight_pingpong_buffer #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int NUM_CHANNELS     = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int FILTER_SIZE      = 3,
  parameter int KERNELS_PER_LINE = 2,
  parameter int BANK_DEPTH       = 256,
  localparam int KSET_W = NUM_CHANNELS * FILTER_SIZE * FILTER_SIZE * DATA_WIDTH,
  localparam int LINE_W = KERNELS_PER_LINE * KSET_W,
  localparam int BEATS  = LINE_W / AXIS_DATA_WIDTH,
  localparam int LW     = $clog2(BANK_DEPTH + 1),
  localparam int AW     = $clog2(BANK_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tlast,
  input  logic                       i_load_start,
  input  logic [LW-1:0]              i_load_lines,
  input  logic                       i_swap,
  input  logic                       i_read_en,
  input  logic [AW-1:0]              i_read_addr,
  output logic [LINE_W-1:0]          o_kernels_packed,
  output logic                       o_rd_valid,
  output logic                       o_load_done,
  output logic                       o_wr_bank,
  output logic                       o_err_tlast
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if ((LINE_W % AXIS_DATA_WIDTH) != 0) begin : g_bad_line_width
      $error("LINE_W must be an integer multiple of AXIS_DATA_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [LW-1:0]     wr_addr;
  logic [LW-1:0]     target;
  logic [LW-1:0]     load_target;
  logic [BW-1:0]     beat;
  logic [LINE_W-1:0] line_buf;
  logic [LINE_W-1:0] line_full;
  logic              hs;
  logic              last_beat;
  logic              line_wr;
  logic              start_ok;
  logic              swap_ok;

  // Both banks live in one array; the bank index is o_wr_bank for writes and
  // its complement for reads, so a read can never collide with a write.
  logic [LINE_W-1:0] mem [2][BANK_DEPTH];

  assign load_target   = (i_load_lines > LW'(BANK_DEPTH)) ? LW'(BANK_DEPTH) : i_load_lines;
  assign s_axis_tready = (state == ST_LOAD);
  assign o_load_done   = (state == ST_DONE);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign last_beat     = (beat == BW'(BEATS - 1));
  assign line_wr       = hs && last_beat;
  assign start_ok      = (state == ST_IDLE) && i_load_start;
  assign swap_ok       = (state == ST_DONE) && i_swap;

  // The final beat goes straight into the bank write without first landing
  // in line_buf, so a line is written in the same cycle as its last beat.
  always_comb begin
    line_full = line_buf;
    line_full[int'(beat) * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] = s_axis_tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: begin
        if (i_load_start) begin
          state_n = (load_target == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (line_wr && ((wr_addr + LW'(1)) == target)) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_swap) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Load bookkeeping and bank select. A tlast before the final beat drops the
  // partial line (beat back to 0, address kept); a missing tlast on the final
  // beat only flags the error and the line is still stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      target      <= '0;
      beat        <= '0;
      o_wr_bank   <= 1'b0;
      o_err_tlast <= 1'b0;
    end else begin
      if (start_ok) begin
        wr_addr     <= '0;
        beat        <= '0;
        target      <= load_target;
        o_err_tlast <= 1'b0;
      end
      if (swap_ok) begin
        o_wr_bank <= ~o_wr_bank;
      end
      if (hs) begin
        if (last_beat) begin
          beat    <= '0;
          wr_addr <= wr_addr + LW'(1);
          if (!s_axis_tlast) begin
            o_err_tlast <= 1'b1;
          end
        end else if (s_axis_tlast) begin
          beat        <= '0;
          o_err_tlast <= 1'b1;
        end else begin
          beat <= beat + BW'(1);
        end
      end
    end
  end

  // Storage is deliberately outside the reset domain: a reset aborts a load
  // but must leave previously written lines intact.
  always_ff @(posedge clk) begin
    if (hs) begin
      line_buf[int'(beat) * AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_tdata;
    end
    if (line_wr) begin
      mem[o_wr_bank][wr_addr[AW-1:0]] <= line_full;
    end
  end

  // Read uses the registered bank select, so a read issued together with a
  // swap still sees the pre-swap read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rd_valid       <= 1'b0;
      o_kernels_packed <= '0;
    end else begin
      o_rd_valid <= i_read_en;
      if (i_read_en) begin
        o_kernels_packed <= mem[~o_wr_bank][i_read_addr];
      end
    end
  end

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb/tb_weight_pingpong_buffer.sv - scoreboard bench for weight_pingpong_buffer
`timescale 1ns/1ps
module tb_weight_pingpong_buffer;
  localparam int W      = 64;
  localparam int LINE_W = 1152;
  localparam int BEATS  = 18;
  localparam int DEPTH  = 256;
  localparam int LW     = 9;
  localparam int AW     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [W-1:0]      s_axis_tdata;
  logic              s_axis_tlast;
  logic              i_load_start;
  logic [LW-1:0]     i_load_lines;
  logic              i_swap;
  logic              i_read_en;
  logic [AW-1:0]     i_read_addr;
  logic [LINE_W-1:0] o_kernels_packed;
  logic              o_rd_valid;
  logic              o_load_done;
  logic              o_wr_bank;
  logic              o_err_tlast;

  always #5 clk = ~clk;

  weight_pingpong_buffer dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .i_load_start     (i_load_start),
    .i_load_lines     (i_load_lines),
    .i_swap           (i_swap),
    .i_read_en        (i_read_en),
    .i_read_addr      (i_read_addr),
    .o_kernels_packed (o_kernels_packed),
    .o_rd_valid       (o_rd_valid),
    .o_load_done      (o_load_done),
    .o_wr_bank        (o_wr_bank),
    .o_err_tlast      (o_err_tlast)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LINE_W-1:0] data;
    int                due;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: two banks of lines, plus the beats of the line in flight.
  logic [LINE_W-1:0] m_bank [2][DEPTH];
  logic              m_wb;
  int                m_addr;
  logic [W-1:0]      m_cur[$];
  logic [LINE_W-1:0] last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LINE_W-1:0] act,
                            input logic [LINE_W-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      errors++;
      idx = 0;
      for (int i = BEATS - 1; i >= 0; i--) begin
        if (act[i*W +: W] !== exp[i*W +: W]) idx = i;
      end
      $display("FAIL %s beat %0d actual=%h required=%h", name, idx,
               act[idx*W +: W], exp[idx*W +: W]);
    end
  endtask

  // Monitor: every o_rd_valid pops one expected line and its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && o_rd_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unexpected actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        check("rd_latency", 64'(cyc), 64'(e.due));
        check_line("rd_data", o_kernels_packed, e.data);
        last_rd = e.data;
      end
    end
  end

  function automatic void model_beat(input logic [W-1:0] d, input bit last);
    logic [LINE_W-1:0] line;
    m_cur.push_back(d);
    if (m_cur.size() == BEATS) begin
      for (int i = 0; i < BEATS; i++) line[i*W +: W] = m_cur[i];
      m_bank[m_wb][m_addr] = line;
      m_addr++;
      m_cur.delete();
    end else if (last) begin
      m_cur.delete();
    end
  endfunction

  task automatic push_beat(input logic [W-1:0] d, input bit last);
    int t;
    t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    while (!s_axis_tready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=no_tready required=tready");
      s_axis_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    model_beat(d, last);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic start_load(input int lines);
    i_load_start = 1'b1;
    i_load_lines = LW'(lines);
    @(negedge clk);
    i_load_start = 1'b0;
    m_addr = 0;
    m_cur.delete();
  endtask

  task automatic do_swap();
    i_swap = 1'b1;
    @(negedge clk);
    i_swap = 1'b0;
    m_wb = ~m_wb;
  endtask

  task automatic read_line(input int addr);
    exp_t e;
    i_read_en   = 1'b1;
    i_read_addr = addr[AW-1:0];
    e.data = m_bank[~m_wb][addr];
    e.due  = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    i_read_en = 1'b0;
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  bit reading;

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    i_load_start  = 1'b0;
    i_load_lines  = '0;
    i_swap        = 1'b0;
    i_read_en     = 1'b0;
    i_read_addr   = '0;
    m_wb          = 1'b0;
    m_addr        = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_tready", s_axis_tready, 0);
    check("rst_wr_bank", o_wr_bank, 0);
    check("rst_load_done", o_load_done, 0);
    check("rst_err", o_err_tlast, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check_line("rst_kernels", o_kernels_packed, '0);

    // Two lines: 1..18 then 0xA0..0xB1, clean framing.
    start_load(2);
    for (int i = 0; i < BEATS; i++) push_beat(64'(i + 1), i == BEATS - 1);
    for (int i = 0; i < BEATS; i++) push_beat(64'(8'hA0 + i), i == BEATS - 1);
    check("load2_tready_low", s_axis_tready, 0);
    check("load2_done", o_load_done, 1);
    check("load2_err", o_err_tlast, 0);
    do_swap();
    check("swap1_wr_bank", o_wr_bank, 1);
    check("swap1_done_clear", o_load_done, 0);
    read_line(0);
    read_line(1);
    @(negedge clk);
    check("rd_valid_drop", o_rd_valid, 0);
    check_line("rd_hold", o_kernels_packed, last_rd);

    // Load bank 1 with 0x55 while bank 0 addr 1 is read every cycle.
    start_load(1);
    reading = 1'b1;
    fork
      begin
        for (int i = 0; i < BEATS; i++) push_beat({8{8'h55}}, i == BEATS - 1);
        reading = 1'b0;
      end
      begin
        while (reading) read_line(1);
      end
    join
    check("load55_done", o_load_done, 1);
    do_swap();
    check("swap2_wr_bank", o_wr_bank, 0);
    read_line(0);

    // Early tlast on beat 5, then one clean line; swap and reload ignored mid-flight.
    start_load(1);
    for (int i = 0; i < 6; i++) push_beat(rand64(), i == 5);
    check("early_tlast_err", o_err_tlast, 1);
    check("early_tlast_not_done", o_load_done, 0);
    i_swap = 1'b1;
    push_beat(rand64(), 1'b0);
    i_swap = 1'b0;
    check("swap_in_load_ignored", o_wr_bank, 0);
    for (int i = 1; i < BEATS; i++) push_beat(rand64(), i == BEATS - 1);
    check("early_tlast_done", o_load_done, 1);
    i_load_start = 1'b1;
    i_load_lines = LW'(5);
    @(negedge clk);
    i_load_start = 1'b0;
    check("start_in_done_ignored", o_load_done, 1);
    check("start_in_done_err_kept", o_err_tlast, 1);
    check("start_in_done_tready", s_axis_tready, 0);
    do_swap();
    read_line(0);

    // Clamped full-depth load of random lines into bank 1.
    start_load(DEPTH + 1);
    check("clamp_err_cleared", o_err_tlast, 0);
    for (int l = 0; l < DEPTH; l++) begin
      for (int b = 0; b < BEATS; b++) push_beat(rand64(), b == BEATS - 1);
    end
    check("clamp_tready_low", s_axis_tready, 0);
    check("clamp_done", o_load_done, 1);
    s_axis_tvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("clamp_no_extra_beat", s_axis_tready, 0);
    end
    s_axis_tvalid = 1'b0;
    do_swap();
    read_line(0);
    read_line(DEPTH - 1);
    for (int i = 0; i < 4; i++) read_line($urandom_range(DEPTH - 1));

    // Zero-line load goes straight to DONE.
    start_load(0);
    check("zero_done", o_load_done, 1);
    check("zero_tready", s_axis_tready, 0);
    do_swap();

    // Reset in the middle of line 3 of a load into bank 1.
    start_load(5);
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < BEATS; b++) push_beat(rand64(), b == BEATS - 1);
    end
    for (int b = 0; b < 10; b++) push_beat(rand64(), 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand64();
    i_read_en     = 1'b1;
    i_read_addr   = '0;
    @(posedge clk);
    i_read_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_tready", s_axis_tready, 0);
    check("arst_wr_bank", o_wr_bank, 0);
    check("arst_load_done", o_load_done, 0);
    check("arst_err", o_err_tlast, 0);
    check("arst_rd_valid", o_rd_valid, 0);
    check_line("arst_kernels", o_kernels_packed, '0);
    s_axis_tvalid = 1'b0;
    m_wb = 1'b0;
    m_cur.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", s_axis_tready, 0);
    start_load(0);
    do_swap();
    start_load(0);
    do_swap();
    for (int i = 0; i < 4; i++) read_line(i);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
